epp_input: RTL and testbench

Host-side command front end for the snake game. It implements a Digilent-style EPP slave on the parallel-port pins and synchronises the host strobes into `clk`. Host writes become the one-cycle direction command (`epp_data`/`epp_wr`) consumed by the game core, plus a restart pulse. Host reads return game status and the score.

---
 rtl/epp_input.sv | 161 ++++++++++++++++
 tb/tb_epp_input.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/epp_input.sv
// EPP slave front end: synchronised host strobes drive direction/restart commands and status/score readback.
// Latency: pwait rises 3 clk after the first edge that samples a strobe low; falls 2 clk after release is sampled.
// Backpressure: pwait holds the host in its strobe until the action is done; one action per strobe however long it is held.
//
// Ports:
//   clk, rst          system clock, async active-low reset
//   astb, dstb, pwr   EPP address strobe, data strobe, direction (all async, strobes active-low)
//   db_in, db_out     EPP data bus from / to the pad; db_oe enables the pad driver
//   pwait             EPP wait/acknowledge
//   game_over, number status and score from the game core
//   epp_data, epp_wr  one-hot direction command and its one-cycle qualifier
//   restart           one-cycle restart pulse
module epp_input #(
    parameter logic [7:0] ADDR_DIR      = 8'h00,
    parameter logic [7:0] ADDR_CTRL     = 8'h01,
    parameter logic [7:0] ADDR_SCORE_LO = 8'h02,
    parameter logic [7:0] ADDR_SCORE_HI = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        astb,
    input  logic        dstb,
    input  logic        pwr,
    input  logic [7:0]  db_in,
    output logic [7:0]  db_out,
    output logic        db_oe,
    output logic        pwait,
    input  logic        game_over,
    input  logic [15:0] number,
    output logic [3:0]  epp_data,
    output logic        epp_wr,
    output logic        restart
);

    typedef enum logic [1:0] {HOLDOFF, IDLE, ACT, WAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  astb_sync, dstb_sync, pwr_sync;
    logic        astb_s, dstb_s, pwr_s;
    logic [1:0]  flush_cnt;
    logic [7:0]  wdata;
    logic [7:0]  addr;
    logic [3:0]  last_dir;
    logic        rd;
    logic        is_addr;
    logic        strobe_rel;
    logic        dir_ok;
    logic [7:0]  rd_mux;

    assign astb_s = astb_sync[1];
    assign dstb_s = dstb_sync[1];
    assign pwr_s  = pwr_sync[1];

    // Release is judged on whichever strobe started the transfer.
    assign strobe_rel = is_addr ? astb_s : dstb_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            astb_sync <= 2'b11;
            dstb_sync <= 2'b11;
            pwr_sync  <= 2'b11;
        end else begin
            astb_sync <= {astb_sync[0], astb};
            dstb_sync <= {dstb_sync[0], dstb};
            pwr_sync  <= {pwr_sync[0], pwr};
        end
    end

    always_comb begin
        dir_ok = 1'b0;
        case (wdata[3:0])
            4'b0001, 4'b0010, 4'b0100, 4'b1000: dir_ok = 1'b1;
            default:                            dir_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_mux = 8'h00;
        if (addr == ADDR_DIR)           rd_mux = {4'b0000, last_dir};
        else if (addr == ADDR_CTRL)     rd_mux = {7'b0000000, game_over};
        else if (addr == ADDR_SCORE_LO) rd_mux = number[7:0];
        else if (addr == ADDR_SCORE_HI) rd_mux = number[15:8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HOLDOFF;
        else      state <= state_nxt;
    end

    // HOLDOFF waits for the synchronisers to flush their reset value of 1
    // before trusting "both strobes high"; otherwise a strobe held low
    // across reset would look released and then be acted on.
    always_comb begin
        state_nxt = state;
        case (state)
            HOLDOFF: if (flush_cnt == 2'd2 && astb_s && dstb_s) state_nxt = IDLE;
            IDLE:    if (!astb_s || !dstb_s)                    state_nxt = ACT;
            ACT:                                                state_nxt = WAIT;
            WAIT:    if (strobe_rel)                            state_nxt = IDLE;
            default:                                            state_nxt = HOLDOFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= 2'd0;
            wdata     <= 8'h00;
            rd        <= 1'b0;
            is_addr   <= 1'b0;
            addr      <= 8'h00;
            last_dir  <= 4'b0001;
            db_out    <= 8'h00;
            db_oe     <= 1'b0;
            pwait     <= 1'b0;
            epp_data  <= 4'b0001;
            epp_wr    <= 1'b0;
            restart   <= 1'b0;
        end else begin
            epp_wr  <= 1'b0;
            restart <= 1'b0;
            case (state)
                HOLDOFF: begin
                    if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
                end
                IDLE: begin
                    if (!astb_s || !dstb_s) begin
                        wdata   <= db_in;
                        rd      <= pwr_s;
                        is_addr <= !astb_s;   // address strobe wins a collision
                    end
                end
                ACT: begin
                    pwait <= 1'b1;
                    db_oe <= rd;
                    if (is_addr) begin
                        if (rd) db_out <= addr;
                        else    addr   <= wdata;
                    end else if (rd) begin
                        db_out <= rd_mux;
                    end else if (addr == ADDR_DIR) begin
                        if (dir_ok) begin
                            epp_data <= wdata[3:0];
                            epp_wr   <= 1'b1;
                            last_dir <= wdata[3:0];
                        end
                    end else if (addr == ADDR_CTRL) begin
                        restart <= wdata[0];
                    end
                end
                WAIT: begin
                    if (strobe_rel) begin
                        pwait <= 1'b0;
                        db_oe <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_epp_input.sv
module tb_epp_input;

    logic        clk = 1'b0;
    logic        rst;
    logic        astb, dstb, pwr;
    logic [7:0]  db_in;
    logic [7:0]  db_out;
    logic        db_oe, pwait;
    logic        game_over;
    logic [15:0] number;
    logic [3:0]  epp_data;
    logic        epp_wr, restart;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int rs_cnt = 0;

    always #5 clk = ~clk;

    epp_input dut (
        .clk(clk), .rst(rst), .astb(astb), .dstb(dstb), .pwr(pwr),
        .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .pwait(pwait),
        .game_over(game_over), .number(number),
        .epp_data(epp_data), .epp_wr(epp_wr), .restart(restart)
    );

    // Count high cycles of the one-cycle strobes.
    always @(negedge clk) begin
        if (epp_wr === 1'b1)  wr_cnt++;
        if (restart === 1'b1) rs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // mode: 0 = astb, 1 = dstb, 2 = both strobes together.
    // lat = sampled edges from strobe fall to pwait high (first sampling edge = 1).
    // rel = sampled edges from release to pwait low.
    task automatic xfer(input int mode, input bit rdir, input logic [7:0] d, input int hold,
                        output logic [7:0] rdat, output int lat, output int rel, output int oe_bad);
        oe_bad = 0; lat = -1; rel = -1; rdat = 8'h00;
        @(posedge clk); #1;
        pwr = rdir; db_in = d;
        repeat (3) @(posedge clk);
        #1;
        if (mode != 1) astb = 1'b0;
        if (mode != 0) dstb = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (pwait) begin lat = k; break; end
            if (db_oe) oe_bad++;
        end
        rdat = db_out;
        if (db_oe !== rdir) oe_bad++;
        repeat (hold) @(posedge clk);
        #1;
        astb = 1'b1; dstb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (!pwait) begin
                rel = k;
                if (db_oe) oe_bad++;
                break;
            end
            if (db_oe !== rdir) oe_bad++;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic txn(input string tag, input int mode, input bit rdir, input logic [7:0] d,
                       input int hold, input logic [7:0] exp_rdat, input int exp_wr, input int exp_rs);
        logic [7:0] rdat;
        int lat, rel, oe_bad, w0, r0;
        w0 = wr_cnt; r0 = rs_cnt;
        xfer(mode, rdir, d, hold, rdat, lat, rel, oe_bad);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_rel"}, rel, 3);
        check({tag, "_oe"},  oe_bad, 0);
        check({tag, "_wr"},  wr_cnt - w0, exp_wr);
        check({tag, "_rs"},  rs_cnt - r0, exp_rs);
        if (rdir) check({tag, "_rdat"}, rdat, exp_rdat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, p;
        rst = 1'b0; astb = 1'b1; dstb = 1'b1; pwr = 1'b0; db_in = 8'h00;
        game_over = 1'b0; number = 16'h0000;
        #12;
        check("rst_pwait",    pwait,    1'b0);
        check("rst_db_oe",    db_oe,    1'b0);
        check("rst_db_out",   db_out,   8'h00);
        check("rst_epp_data", epp_data, 4'b0001);
        check("rst_epp_wr",   epp_wr,   1'b0);
        check("rst_restart",  restart,  1'b0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(posedge clk);

        // Address write then direction write
        txn("aw00",   0, 0, 8'h00, 0, 8'h00, 0, 0);
        txn("dir02",  1, 0, 8'h02, 0, 8'h00, 1, 0);
        check("dir02_data", epp_data, 4'b0010);

        // Invalid direction is ignored; readback keeps prior direction
        txn("dir05",  1, 0, 8'h05, 0, 8'h00, 0, 0);
        check("dir05_data", epp_data, 4'b0010);
        txn("rddir",  1, 1, 8'h00, 0, 8'h02, 0, 0);

        // Score readback and address readback
        number = 16'h1234;
        txn("aw02",   0, 0, 8'h02, 0, 8'h00, 0, 0);
        txn("rdlo",   1, 1, 8'h00, 0, 8'h34, 0, 0);
        txn("aw03",   0, 0, 8'h03, 0, 8'h00, 0, 0);
        txn("rdhi",   1, 1, 8'h00, 2, 8'h12, 0, 0);
        txn("rdaddr", 0, 1, 8'h00, 0, 8'h03, 0, 0);

        // Control register
        game_over = 1'b1;
        txn("aw01",   0, 0, 8'h01, 0, 8'h00, 0, 0);
        txn("rdctl1", 1, 1, 8'h00, 0, 8'h01, 0, 0);
        txn("wrst1",  1, 0, 8'h01, 0, 8'h00, 0, 1);
        txn("wrst0",  1, 0, 8'h00, 0, 8'h00, 0, 0);
        game_over = 1'b0;
        txn("rdctl0", 1, 1, 8'h00, 0, 8'h00, 0, 0);

        // Unmapped address reads zero and ignores writes
        txn("aw07",   0, 0, 8'h07, 0, 8'h00, 0, 0);
        txn("rdunm",  1, 1, 8'h00, 0, 8'h00, 0, 0);
        txn("wrunm",  1, 0, 8'h02, 0, 8'h00, 0, 0);

        // Reset while dstb is low in WAIT
        txn("aw00b",  0, 0, 8'h00, 0, 8'h00, 0, 0);
        @(posedge clk); #1 pwr = 1'b0; db_in = 8'h08;
        repeat (3) @(posedge clk);
        #1 dstb = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_pwait_pre", pwait,    1'b1);
        check("mid_data_pre",  epp_data, 4'b1000);
        rst = 1'b0;
        #1;
        check("mid_pwait_rst", pwait,    1'b0);
        check("mid_oe_rst",    db_oe,    1'b0);
        check("mid_data_rst",  epp_data, 4'b0001);
        @(posedge clk); #1 rst = 1'b1;
        w0 = wr_cnt; p = 0;
        repeat (12) begin
            @(negedge clk);
            if (pwait) p++;
        end
        check("mid_wr_after",    wr_cnt - w0, 0);
        check("mid_pwait_after", p, 0);
        @(posedge clk); #1 dstb = 1'b1;
        repeat (5) @(posedge clk);
        txn("dir04",  1, 0, 8'h04, 0, 8'h00, 1, 0);
        check("dir04_data", epp_data, 4'b0100);

        // Strobe collision: address write wins
        txn("aw00c",  0, 0, 8'h00, 0, 8'h00, 0, 0);
        txn("coll",   2, 0, 8'h01, 0, 8'h00, 0, 0);
        txn("rdcoll", 0, 1, 8'h00, 0, 8'h01, 0, 0);

        // Long dstb hold yields exactly one epp_wr
        txn("aw00d",  0, 0, 8'h00, 0, 8'h00, 0, 0);
        txn("long",   1, 0, 8'h01, 100, 8'h00, 1, 0);
        check("long_data", epp_data, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
